// File: rtl/iob_regfile_2p_reader.sv
// Purpose : read-side initiator for the two-port register file; streams a contiguous
//           block of registers (base, len) out over a valid/ready interface.
// Latency : start accepted at cycle N -> raddr driven at N+1 -> first word valid at N+2;
//           one word per cycle while the consumer holds ready high.
// Backpr. : m_data_o/m_last_o/raddr_o hold while m_valid_o=1 and m_ready_i=0; no beat is lost.
//
// Ports   : clk_i/cke_i/rst_i   clock, clock enable (all state holds when low), sync active-high reset
//           start_i/base_i/len_i transfer request, sampled only while idle
//           busy_o/done_o        transfer in progress / one-cycle completion pulse
//           raddr_o/rdata_i      register file read port (rdata combinational on raddr)
//           m_valid_o/m_ready_i/m_data_o/m_last_o  output stream
// Option  : define IOB_REGFILE_2P_READER_ABORT_EN to add abort_i (cancels a transfer, no done pulse).
module iob_regfile_2p_reader #(
    parameter int RDATA_W = 32,
    parameter int RADDR_W = 4,
    parameter int LEN_W   = RADDR_W + 1
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [RADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]   len_i,
`ifdef IOB_REGFILE_2P_READER_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [RADDR_W-1:0] raddr_o,
    input  logic [RDATA_W-1:0] rdata_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [RDATA_W-1:0] m_data_o,
    output logic               m_last_o
);

    // S_FIN is the single cycle in which done_o pulses; busy_o stays high through
    // it so that done_o and busy_o fall on the same edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [RADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [RDATA_W-1:0] r_data;
    logic               r_last;

    logic w_abort;
    logic w_adv;
    logic w_hs_last;

`ifdef IOB_REGFILE_2P_READER_ABORT_EN
    assign w_abort = abort_i & r_busy;
`else
    assign w_abort = 1'b0;
`endif

    // Output register may take a new word when empty or when its word leaves this cycle.
    assign w_adv     = ~r_valid | m_ready_i;
    assign w_hs_last = r_valid & m_ready_i & r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (cke_i) begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Abort wins over a same-cycle handshake: the presented beat is dropped.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            if (len_i != '0) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                                r_ptr   <= base_i;
                                r_rem   <= len_i;
                            end else begin
                                // Empty transfer: completes immediately, never goes busy.
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_adv) begin
                            if (r_rem != '0) begin
                                r_data  <= rdata_i;
                                r_valid <= 1'b1;
                                r_last  <= (r_rem == LEN_W'(1));
                                r_ptr   <= r_ptr + RADDR_W'(1);  // wraps modulo 2**RADDR_W
                                r_rem   <= r_rem - LEN_W'(1);
                            end else begin
                                r_valid <= 1'b0;
                            end
                        end
                        if (w_hs_last) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign raddr_o   = r_ptr;
    assign m_valid_o = r_valid;
    assign m_data_o  = r_data;
    assign m_last_o  = r_last;

endmodule
